// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the register-file write
//                front end (address/data widths, register count, the $0
//                address and the buffered write-entry record).
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_entry_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_fifo
//  Description : DEPTH-entry synchronous FIFO of register-file write entries
//                for long-latency results. Head is presented combinationally.
//  Ports       : clk, reset (sync, active-high)
//                i_push/i_data  - enqueue an entry at the tail
//                i_pop          - drop the head entry
//                o_head         - current head entry
//                o_empty        - no entries held
//                o_count        - registered occupancy (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  wr_entry_t                i_data,
    input  logic                     i_pop,
    output wr_entry_t                o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_entry_t          mem_q [DEPTH];
    wr_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed when count_q > 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule : regfile_write_fifo
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Write-side front end of the 32x32 register file. Merges the
//                pipeline writeback (highest priority, never stalled) with
//                buffered long-latency results into one write port, and keeps
//                a pending-destination scoreboard for decode stalls.
//  Ports       : clk, reset (sync, active-high)
//                wb_write/wb_addr/wb_data      - pipeline writeback
//                issue_valid/issue_addr        - long-latency op issued
//                lr_valid/lr_ready/lr_addr/lr_data - result handshake
//                read1/read2 -> busy1/busy2    - scoreboard queries
//                write/write_address/write_Data - register-file write port
//  Config      : WRITE_BYPASS_EN - when defined, a result offered while the
//                port is idle and the buffer is empty is written in the same
//                cycle instead of being buffered.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic                  lr_valid,
    output logic                  lr_ready,
    input  logic [REG_ADDR_W-1:0] lr_addr,
    input  logic [DATA_W-1:0]     lr_data,
    input  logic [REG_ADDR_W-1:0] read1,
    input  logic [REG_ADDR_W-1:0] read2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  write,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0]     write_Data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wr_entry_t          w_head;
    wr_entry_t          w_lr_entry;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_accept;
    logic               w_bypass;
    logic               w_drain;
    logic               w_push;
    logic               w_lr_fire;
    logic               w_port_busy;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    assign w_lr_entry = '{addr: lr_addr, data: lr_data};

    // Ready comes from the registered count only, so a full buffer cannot
    // accept on the same edge that it drains.
    assign lr_ready = (w_count != CNT_W'(DEPTH));
    assign w_accept = lr_valid && lr_ready;
    assign w_drain  = !wb_write && !w_empty;

`ifdef WRITE_BYPASS_EN
    assign w_bypass = !wb_write && w_empty && lr_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push    = w_accept && !w_bypass;
    assign w_lr_fire = w_drain || w_bypass;

    regfile_write_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_lr_entry),
        .i_pop   (w_drain),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Port mux: writeback > buffered head > bypassed offer. Writes to $0
    // still occupy the slot (and pop the buffer) but never assert write.
    always_comb begin
        w_port_busy   = 1'b0;
        write_address = REG_ZERO;
        write_Data    = '0;
        if (wb_write) begin
            w_port_busy   = 1'b1;
            write_address = wb_addr;
            write_Data    = wb_data;
        end else if (w_drain) begin
            w_port_busy   = 1'b1;
            write_address = w_head.addr;
            write_Data    = w_head.data;
        end else if (w_bypass) begin
            w_port_busy   = 1'b1;
            write_address = lr_addr;
            write_Data    = lr_data;
        end
    end

    assign write = w_port_busy && (write_address != REG_ZERO);

    // Clear first, then set, so an issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (w_lr_fire) begin
            pending_d[write_address] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy1 = pending_q[read1];
    assign busy2 = pending_q[read2];

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_addr;
    logic [31:0] lr_data;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic        busy1;
    logic        busy2;
    logic        write;
    logic [4:0]  write_address;
    logic [31:0] write_Data;

    int n_checks;
    int n_fails;

    regfile_write_arbiter #(
        .DEPTH         (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_write      (wb_write),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .lr_valid      (lr_valid),
        .lr_ready      (lr_ready),
        .lr_addr       (lr_addr),
        .lr_data       (lr_data),
        .read1         (read1),
        .read2         (read2),
        .busy1         (busy1),
        .busy2         (busy2),
        .write         (write),
        .write_address (write_address),
        .write_Data    (write_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and
    // outputs sampled 1 time unit later, well away from either edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_write = en;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic lr(input logic v, input logic [4:0] a, input logic [31:0] d);
        lr_valid = v;
        lr_addr  = a;
        lr_data  = d;
    endtask

    task automatic port(input string tag, input logic en,
                        input logic [4:0] a, input logic [31:0] d);
        check_val({tag, "_write"}, 32'(write), 32'(en));
        if (en) begin
            check_val({tag, "_addr"}, 32'(write_address), 32'(a));
            check_val({tag, "_data"}, write_Data, d);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset       = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        lr(1'b0, 5'd0, 32'h0);
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        read1       = 5'd3;
        read2       = 5'd8;
        step();
        step();
        reset = 1'b0;
        settle();

        // Reset state
        check_val("rst_ready", 32'(lr_ready), 32'd1);
        check_val("rst_write", 32'(write), 32'd0);
        check_val("rst_busy1", 32'(busy1), 32'd0);
        check_val("rst_busy2", 32'(busy2), 32'd0);

        // 1: writeback is combinational
        wb(1'b1, 5'd5, 32'h0000_1234);
        settle();
        port("t1", 1'b1, 5'd5, 32'h0000_1234);
        step();
        wb(1'b0, 5'd0, 32'h0);

        // 2: issue r8, result three cycles later
        issue_valid = 1'b1;
        issue_addr  = 5'd8;
        read1       = 5'd8;
        step();
        issue_valid = 1'b0;
        settle();
        check_val("t2_busy_after_issue", 32'(busy1), 32'd1);
        step();
        step();
        lr(1'b1, 5'd8, 32'hDEAD_BEEF);
        settle();
        check_val("t2_busy_offer", 32'(busy1), 32'd1);
        check_val("t2_ready", 32'(lr_ready), 32'd1);
`ifdef WRITE_BYPASS_EN
        port("t2_bypass", 1'b1, 5'd8, 32'hDEAD_BEEF);
        step();
        lr(1'b0, 5'd0, 32'h0);
        settle();
        check_val("t2_busy_clear", 32'(busy1), 32'd0);
        port("t2_idle", 1'b0, 5'd0, 32'h0);
`else
        port("t2_no_early", 1'b0, 5'd0, 32'h0);
        step();
        lr(1'b0, 5'd0, 32'h0);
        settle();
        port("t2_drain", 1'b1, 5'd8, 32'hDEAD_BEEF);
        check_val("t2_busy_during_write", 32'(busy1), 32'd1);
        step();
        check_val("t2_busy_clear", 32'(busy1), 32'd0);
        port("t2_idle", 1'b0, 5'd0, 32'h0);
`endif

        // 3: writeback holds the port for 4 cycles, results queue behind it
        wb(1'b1, 5'd20, 32'hA000_0020);
        lr(1'b1, 5'd9, 32'd1);
        settle();
        port("t3_c1", 1'b1, 5'd20, 32'hA000_0020);
        step();
        wb(1'b1, 5'd21, 32'hA000_0021);
        lr(1'b1, 5'd10, 32'd2);
        settle();
        port("t3_c2", 1'b1, 5'd21, 32'hA000_0021);
        step();
        wb(1'b1, 5'd22, 32'hA000_0022);
        lr(1'b0, 5'd0, 32'h0);
        settle();
        port("t3_c3", 1'b1, 5'd22, 32'hA000_0022);
        check_val("t3_full", 32'(lr_ready), 32'd0);
        step();
        wb(1'b1, 5'd23, 32'hA000_0023);
        settle();
        port("t3_c4", 1'b1, 5'd23, 32'hA000_0023);
        step();
        wb(1'b0, 5'd0, 32'h0);
        settle();
        port("t3_c5", 1'b1, 5'd9, 32'd1);
        step();
        port("t3_c6", 1'b1, 5'd10, 32'd2);
        step();
        port("t3_c7", 1'b0, 5'd0, 32'h0);
        check_val("t3_ready", 32'(lr_ready), 32'd1);

        // 4: three offers into a 2-deep buffer while writeback is busy
        wb(1'b1, 5'd24, 32'hB000_0024);
        lr(1'b1, 5'd11, 32'h11);
        settle();
        check_val("t4_ready1", 32'(lr_ready), 32'd1);
        step();
        wb(1'b1, 5'd25, 32'hB000_0025);
        lr(1'b1, 5'd12, 32'h12);
        settle();
        check_val("t4_ready2", 32'(lr_ready), 32'd1);
        step();
        wb(1'b1, 5'd26, 32'hB000_0026);
        lr(1'b1, 5'd13, 32'h13);
        settle();
        check_val("t4_full", 32'(lr_ready), 32'd0);
        port("t4_wb", 1'b1, 5'd26, 32'hB000_0026);
        step();
        wb(1'b0, 5'd0, 32'h0);
        settle();
        check_val("t4_full_on_drain", 32'(lr_ready), 32'd0);
        port("t4_d1", 1'b1, 5'd11, 32'h11);
        step();
        check_val("t4_ready_after_pop", 32'(lr_ready), 32'd1);
        port("t4_d2", 1'b1, 5'd12, 32'h12);
        step();
        lr(1'b0, 5'd0, 32'h0);
        settle();
        port("t4_d3", 1'b1, 5'd13, 32'h13);
        step();
        port("t4_empty", 1'b0, 5'd0, 32'h0);
        check_val("t4_ready_end", 32'(lr_ready), 32'd1);

        // 5: register 0
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        settle();
        port("t5_wb0", 1'b0, 5'd0, 32'h0);
        step();
        wb(1'b0, 5'd0, 32'h0);
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        read1       = 5'd0;
        lr(1'b1, 5'd0, 32'h55);
        settle();
        port("t5_lr0_offer", 1'b0, 5'd0, 32'h0);
        step();
        issue_valid = 1'b0;
        lr(1'b0, 5'd0, 32'h0);
        settle();
        port("t5_lr0_drain", 1'b0, 5'd0, 32'h0);
        check_val("t5_busy0", 32'(busy1), 32'd0);
        step();
        port("t5_after", 1'b0, 5'd0, 32'h0);
        check_val("t5_ready", 32'(lr_ready), 32'd1);
        check_val("t5_busy0_late", 32'(busy1), 32'd0);

        // 6: reset with a full buffer and r3 pending
        read1       = 5'd3;
        read2       = 5'd3;
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        wb(1'b1, 5'd27, 32'hC000_0027);
        lr(1'b1, 5'd15, 32'h15);
        step();
        issue_valid = 1'b0;
        wb(1'b1, 5'd28, 32'hC000_0028);
        lr(1'b1, 5'd16, 32'h16);
        step();
        lr(1'b0, 5'd0, 32'h0);
        settle();
        check_val("t6_busy1_pre", 32'(busy1), 32'd1);
        check_val("t6_busy2_pre", 32'(busy2), 32'd1);
        check_val("t6_full_pre", 32'(lr_ready), 32'd0);
        reset = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        step();
        reset = 1'b0;
        settle();
        check_val("t6_ready", 32'(lr_ready), 32'd1);
        check_val("t6_busy1", 32'(busy1), 32'd0);
        check_val("t6_busy2", 32'(busy2), 32'd0);
        port("t6_nowrite", 1'b0, 5'd0, 32'h0);
        step();
        port("t6_nowrite2", 1'b0, 5'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
